// File: rtl/mem_pkg.sv
// Shared definitions for the D-memory responder.
//   mem_state_t   : responder FSM states
//   WORD_ADDR_LSB : lowest byte-address bit that selects a word
//   LAT_W         : width of the wait-cycle counter
//   DATA_W        : memory word width
//   word_in_range : true when a word index falls inside a memory of 2**aw words
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ACK
  } mem_state_t;

  localparam int WORD_ADDR_LSB = 2;
  localparam int LAT_W         = 4;
  localparam int DATA_W        = 32;

  // Every index bit at or above aw must be zero for the word to exist.
  function automatic logic word_in_range(input logic [31-WORD_ADDR_LSB:0] idx,
                                         input int aw);
    return (idx >> aw) == '0;
  endfunction

endpackage

// File: rtl/byte_lane_ram.sv
// Word-organised storage with per-byte write enables and a registered read port.
//   clk_i    : clock, rising edge
//   addr_i   : word address shared by read and write
//   we_i     : write strobe; only lanes with be_i[i] set are updated
//   be_i     : byte-lane enables, bit i covers wdata_i[8i+7:8i]
//   wdata_i  : write data
//   re_i     : load the read register from the addressed word
//   clr_i    : force the read register to zero (wins over re_i)
//   rdata_o  : read register, holds its value until the next re_i/clr_i
module byte_lane_ram
  import mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic              clk_i,
  input  logic [AW-1:0]     addr_i,
  input  logic              we_i,
  input  logic [3:0]        be_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic              clr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH_WORDS];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    for (int i = 0; i < 4; i++) begin
      if (we_i && be_i[i]) begin
        mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
      end
    end
  end

  // The read register doubles as the responder's ReadData holding register,
  // so it carries its own clear for reset and out-of-range reads.
  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/data_memory_responder.sv
// Responder side of the core's D-memory interface. Accepts one read or write
// request at a time, waits LATENCY cycles, performs the access on the edge
// into ACK and pulses Ack for one cycle.
//   CLK         : clock, rising edge
//   RST         : synchronous active-low reset
//   Address     : byte address, word index is Address[31:2]
//   WriteData   : lane-aligned store data
//   ReadEnable  : read request, held until Ack
//   WriteEnable : write request, held until Ack (wins if both are high)
//   ByteEnable  : write lane mask
//   ReadData    : read result, valid with Ack and held until the next read
//   Ack         : one-cycle completion pulse
//   Error       : high with Ack for an out-of-range access
module data_memory_responder
  import mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [31:0]       Address,
  input  logic [DATA_W-1:0] WriteData,
  input  logic              ReadEnable,
  input  logic              WriteEnable,
  input  logic [3:0]        ByteEnable,
  output logic [DATA_W-1:0] ReadData,
  output logic              Ack,
  output logic              Error
);

  localparam int IDX_W = 32 - WORD_ADDR_LSB;
  localparam int AW    = $clog2(DEPTH_WORDS);
  localparam bit ZERO_LAT = (LATENCY == 0);
  localparam logic [LAT_W-1:0] LAT_LOAD = (LATENCY > 0) ? LAT_W'(LATENCY - 1) : '0;

  mem_state_t        state_q, state_d;
  logic [LAT_W-1:0]  cnt_q, cnt_d;
  logic              ack_q;
  logic              err_q;

  logic [IDX_W-1:0]  idx_q;
  logic [DATA_W-1:0] wdata_q;
  logic [3:0]        be_q;
  logic              is_wr_q;

  logic              req;
  logic              enter_ack;
  logic              commit;
  logic [IDX_W-1:0]  c_idx;
  logic [DATA_W-1:0] c_wdata;
  logic [3:0]        c_be;
  logic              c_wr;
  logic              c_in_range;
  logic              ram_we, ram_re, ram_clr;
  logic              addr_lsb_unused;

  assign addr_lsb_unused = ^Address[WORD_ADDR_LSB-1:0];
  assign req = ReadEnable | WriteEnable;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    enter_ack = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req) begin
          if (ZERO_LAT) begin
            state_d   = ACK;
            enter_ack = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = LAT_LOAD;
          end
        end
      end
      WAIT: begin
        // Initiator withdrawing both enables aborts the request outright.
        if (!req) begin
          state_d = IDLE;
        end else if (cnt_q == '0) begin
          state_d   = ACK;
          enter_ack = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ACK: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // With zero latency the access commits on the accepting edge, before the
  // latch registers hold the request, so the live inputs are used instead.
  always_comb begin
    if (state_q == IDLE) begin
      c_idx   = Address[31:WORD_ADDR_LSB];
      c_wdata = WriteData;
      c_be    = ByteEnable;
      c_wr    = WriteEnable;
    end else begin
      c_idx   = idx_q;
      c_wdata = wdata_q;
      c_be    = be_q;
      c_wr    = is_wr_q;
    end
  end

  // Reset on the commit edge must suppress the access.
  assign commit     = enter_ack & RST;
  assign c_in_range = word_in_range(c_idx, AW);
  assign ram_we     = commit & c_wr & c_in_range;
  assign ram_re     = commit & ~c_wr & c_in_range;
  assign ram_clr    = ~RST | (commit & ~c_wr & ~c_in_range);

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ack_q   <= commit;
      err_q   <= commit & ~c_in_range;
    end
  end

  // Request latch: data only, captured when a request is accepted in IDLE.
  always_ff @(posedge CLK) begin
    if (state_q == IDLE && req) begin
      idx_q   <= Address[31:WORD_ADDR_LSB];
      wdata_q <= WriteData;
      be_q    <= ByteEnable;
      is_wr_q <= WriteEnable;
    end
  end

  byte_lane_ram #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_ram (
    .clk_i   (CLK),
    .addr_i  (c_idx[AW-1:0]),
    .we_i    (ram_we),
    .be_i    (c_be),
    .wdata_i (c_wdata),
    .re_i    (ram_re),
    .clr_i   (ram_clr),
    .rdata_o (ReadData)
  );

  assign Ack   = ack_q;
  assign Error = err_q;

endmodule

// File: tb/tb_data_memory_responder.sv
module tb_data_memory_responder;

  logic        clk;
  logic        rst;

  logic [31:0] addr2, wd2, rd2;
  logic        re2, we2, ack2, err2;
  logic [3:0]  be2;

  logic [31:0] addr0, wd0, rd0;
  logic        re0, we0, ack0, err0;
  logic [3:0]  be0;

  int checks = 0;
  int errors = 0;

  data_memory_responder #(.DEPTH_WORDS(1024), .LATENCY(2)) dut (
    .CLK(clk), .RST(rst), .Address(addr2), .WriteData(wd2),
    .ReadEnable(re2), .WriteEnable(we2), .ByteEnable(be2),
    .ReadData(rd2), .Ack(ack2), .Error(err2)
  );

  data_memory_responder #(.DEPTH_WORDS(1024), .LATENCY(0)) dut0 (
    .CLK(clk), .RST(rst), .Address(addr0), .WriteData(wd0),
    .ReadEnable(re0), .WriteEnable(we0), .ByteEnable(be0),
    .ReadData(rd0), .Ack(ack0), .Error(err0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit z, input logic re, input logic we, input logic [31:0] a,
                       input logic [31:0] wd, input logic [3:0] be);
    if (z) begin
      re0 = re; we0 = we; addr0 = a; wd0 = wd; be0 = be;
    end else begin
      re2 = re; we2 = we; addr2 = a; wd2 = wd; be2 = be;
    end
  endtask

  // One complete transaction: drive at a falling edge, count falling edges
  // until Ack is seen, release the enables inside the Ack cycle.
  task automatic access(input bit z, input bit wr, input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] be, input int exp_lat, input bit chk_rd,
                        input logic [31:0] exp_rd, input logic exp_err, input string tag);
    int n;
    bit got;
    @(negedge clk);
    drive(z, ~wr, wr, a, wd, be);
    n = 0;
    got = 1'b0;
    while (!got && n < 20) begin
      @(negedge clk);
      n++;
      got = z ? ack0 : ack2;
    end
    drive(z, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    check({tag, "_lat"}, n, exp_lat);
    if (chk_rd) check({tag, "_rd"}, z ? rd0 : rd2, exp_rd);
    check({tag, "_err"}, z ? err0 : err2, exp_err);
    @(negedge clk);
    check({tag, "_ackdrop"}, z ? ack0 : ack2, 1'b0);
    check({tag, "_errdrop"}, z ? err0 : err2, 1'b0);
  endtask

  initial begin
    int nack;
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    repeat (3) @(negedge clk);
    check("rst_ack", ack2, 1'b0);
    check("rst_err", err2, 1'b0);
    check("rst_rd", rd2, 32'h0);
    check("rst_rd0", rd0, 32'h0);
    rst = 1'b1;

    // LATENCY=2: Ack three cycles after the request is driven
    access(0, 1, 32'h10, 32'hDEADBEEF, 4'hF, 3, 0, 32'h0, 1'b0, "wr10");
    access(0, 0, 32'h10, 32'h0, 4'h0, 3, 1, 32'hDEADBEEF, 1'b0, "rd10");

    // Partial write: lanes 0 and 2 replaced
    access(0, 1, 32'h20, 32'h11223344, 4'hF, 3, 0, 32'h0, 1'b0, "wr20a");
    access(0, 1, 32'h20, 32'hAABBCCDD, 4'b0101, 3, 0, 32'h0, 1'b0, "wr20b");
    check("rd_held_over_writes", rd2, 32'hDEADBEEF);
    access(0, 0, 32'h23, 32'h0, 4'h0, 3, 1, 32'h11BB33DD, 1'b0, "rd20");
    access(0, 1, 32'h20, 32'hFFFFFFFF, 4'h0, 3, 0, 32'h0, 1'b0, "wr20_nobe");
    access(0, 0, 32'h20, 32'h0, 4'h0, 3, 1, 32'h11BB33DD, 1'b0, "rd20_nobe");

    // Out of range: index DEPTH_WORDS aliases word 0 in the low bits
    access(0, 1, 32'h0, 32'hCAFEF00D, 4'hF, 3, 0, 32'h0, 1'b0, "wr0");
    access(0, 0, 32'h1000, 32'h0, 4'h0, 3, 1, 32'h0, 1'b1, "rd_oor");
    access(0, 1, 32'h1000, 32'hFFFFFFFF, 4'hF, 3, 0, 32'h0, 1'b1, "wr_oor");
    check("rd_held_after_oor_wr", rd2, 32'h0);
    access(0, 0, 32'h0, 32'h0, 4'h0, 3, 1, 32'hCAFEF00D, 1'b0, "rd0_after_oor");

    // Abort after one WAIT cycle
    access(0, 1, 32'h40, 32'h01020304, 4'hF, 3, 0, 32'h0, 1'b0, "wr40");
    @(negedge clk);
    drive(0, 1'b0, 1'b1, 32'h40, 32'h99999999, 4'hF);
    @(negedge clk);
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    nack = 0;
    repeat (6) begin
      @(negedge clk);
      if (ack2) nack++;
    end
    check("abort_no_ack", nack, 0);
    access(0, 0, 32'h40, 32'h0, 4'h0, 3, 1, 32'h01020304, 1'b0, "rd40");

    // Reset on the edge that would enter ACK
    access(0, 1, 32'h30, 32'h0BADC0DE, 4'hF, 3, 0, 32'h0, 1'b0, "wr30a");
    access(0, 0, 32'h40, 32'h0, 4'h0, 3, 1, 32'h01020304, 1'b0, "rd40b");
    @(negedge clk);
    drive(0, 1'b0, 1'b1, 32'h30, 32'h12345678, 4'hF);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rstack_ack", ack2, 1'b0);
    check("rstack_err", err2, 1'b0);
    check("rstack_rd", rd2, 32'h0);
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    rst = 1'b1;
    nack = 0;
    repeat (4) begin
      @(negedge clk);
      if (ack2) nack++;
    end
    check("rstack_no_ack", nack, 0);
    access(0, 0, 32'h30, 32'h0, 4'h0, 3, 1, 32'h0BADC0DE, 1'b0, "rd30");

    // LATENCY=0 instance
    access(1, 1, 32'h0, 32'h00000A0A, 4'hF, 1, 0, 32'h0, 1'b0, "z_wr0");
    access(1, 1, 32'h4, 32'h0000B0B0, 4'hF, 1, 0, 32'h0, 1'b0, "z_wr4");
    @(negedge clk);
    drive(1, 1'b1, 1'b0, 32'h0, 32'h0, 4'h0);
    @(negedge clk);
    check("z_b2b_ack1", ack0, 1'b1);
    check("z_b2b_rd1", rd0, 32'h00000A0A);
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    @(negedge clk);
    check("z_b2b_gap", ack0, 1'b0);
    drive(1, 1'b1, 1'b0, 32'h4, 32'h0, 4'h0);
    @(negedge clk);
    check("z_b2b_ack2", ack0, 1'b1);
    check("z_b2b_rd2", rd0, 32'h0000B0B0);
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    @(negedge clk);
    check("z_b2b_end", ack0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
